// File: rtl/mux_pipe_n_w.sv
// mux_pipe_n_w: pipelined N:1 WIDTH-bit two-level tree mux with valid/ready handshake
module mux_pipe_n_w #(
  parameter int WIDTH      = 32,
  parameter int SEL_BITS   = 5,
  parameter int GROUP_BITS = 4,
  parameter bit MID_REG    = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [(2**SEL_BITS)*WIDTH-1:0] in_data,
  input  logic [SEL_BITS-1:0]           in_sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [SEL_BITS-1:0]           out_sel,
  output logic                          out_valid,
  input  logic                          out_ready
);
  localparam int NG = 2**(SEL_BITS-GROUP_BITS);
  localparam int GS = 2**GROUP_BITS;
  logic [NG*WIDTH-1:0]  grp;
  logic [NG*WIDTH-1:0]  st_grp;
  logic [SEL_BITS-1:0]  st_sel;
  logic [WIDTH-1:0]     st_data;
  logic                 st_valid;
  logic                 out_ready_stage;
  always_comb begin
    grp = '0;
    for (int g = 0; g < NG; g++)
      grp[g*WIDTH +: WIDTH] = in_data[(g*GS + int'(in_sel[GROUP_BITS-1:0]))*WIDTH +: WIDTH];
  end
  assign out_ready_stage = !out_valid || out_ready;
  generate
    if (MID_REG) begin : g_mid
      logic                mid_valid;
      logic [NG*WIDTH-1:0] mid_grp;
      logic [SEL_BITS-1:0] mid_sel;
      assign in_ready = !mid_valid || out_ready_stage;
      // mid stage is free whenever it is empty or its content moves on this edge
      always_ff @(posedge clock or negedge reset)
        if (!reset) begin
          mid_valid <= 1'b0;
          mid_grp   <= '0;
          mid_sel   <= '0;
        end else if (in_ready) begin
          mid_valid <= in_valid;
          if (in_valid) begin
            mid_grp <= grp;
            mid_sel <= in_sel;
          end
        end
      assign st_valid = mid_valid;
      assign st_grp   = mid_grp;
      assign st_sel   = mid_sel;
    end else begin : g_direct
      assign in_ready = out_ready_stage;
      assign st_valid = in_valid;
      assign st_grp   = grp;
      assign st_sel   = in_sel;
    end
  endgenerate
  assign st_data = st_grp[int'(st_sel >> GROUP_BITS)*WIDTH +: WIDTH];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (out_ready_stage) begin
      out_valid <= st_valid;
      if (st_valid) begin
        out_data <= st_data;
        out_sel  <= st_sel;
      end
    end
endmodule

// File: doc/mux_pipe_n_w.md
Name: mux_pipe_n_w

Overview:
Parametrised N:1, WIDTH-bit selection block for the processor datapath, e.g. register-file read ports and writeback source selection. It is the registered, elastic successor to the fixed 32:1 single-bit tree mux. Selection is a two-level tree: first level within groups of 2^GROUP_BITS inputs, second level across groups. Results flow through one or two pipeline stages under a valid/ready handshake, so the mux can sit on timing-critical paths without a combinational in-to-out data path.

Parameters:
WIDTH, 32, data bits per input slot
SEL_BITS, 5, select width; N = 2^SEL_BITS inputs
GROUP_BITS, 4, low select bits resolved at tree level 1 (1 <= GROUP_BITS <= SEL_BITS)
MID_REG, 1, 1 = register between tree levels (latency 2); 0 = level 1 combinational (latency 1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_data  in  N*WIDTH  flattened inputs; slot i = in_data[i*WIDTH +: WIDTH]
in_sel  in  SEL_BITS  slot index
in_valid  in  1  request valid
in_ready  out  1  block accepts request this cycle
out_data  out  WIDTH  selected slot value
out_sel  out  SEL_BITS  select that produced out_data
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset (reset=0, async): out_valid=0, out_data=0, out_sel=0, mid-stage valid=0, mid-stage data/select=0. in_ready evaluates to 1 while in reset. Any in-flight result is discarded.
- Transfer rules: input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Level 1: for each group g in 0..2^(SEL_BITS-GROUP_BITS)-1, pick slot g*2^GROUP_BITS + in_sel[GROUP_BITS-1:0].
- Level 2: pick group in_sel[SEL_BITS-1:GROUP_BITS]. If GROUP_BITS == SEL_BITS, level 2 is a pass-through of the single group.
- MID_REG=0:
  - Single output stage.
  - in_ready = !out_valid || out_ready.
  - On input transfer: out_data <= selected slot, out_sel <= in_sel, out_valid <= 1.
  - Else on output transfer: out_valid <= 0.
  - Latency 1 cycle; throughput 1/cycle.
- MID_REG=1:
  - Mid stage holds level-1 group outputs plus registered in_sel.
  - mid_ready = !mid_valid || out_ready_stage, where out_ready_stage = !out_valid || out_ready.
  - in_ready = mid_ready.
  - Mid advances into the output stage when mid_valid && out_ready_stage; level 2 uses the registered select.
  - Latency 2 cycles; throughput 1/cycle under continuous out_ready=1.
- Stall: when out_ready=0, out_data/out_sel/out_valid hold stable. The mid stage holds once full. in_ready deasserts only when all stages are full.
- No data loss or duplication. A request issued while the pipeline is full is not accepted until in_ready=1. Ordering is FIFO.
- Simultaneous output transfer and new arrival in the same cycle: the stage reloads and out_valid stays 1, with no bubble.
- in_data and in_sel are sampled only on input transfer. Later changes do not affect accepted results.
- in_sel is always in range (N = 2^SEL_BITS); there is no out-of-range case.
- Data path has no combinational in_data to out_data path. in_ready depends combinationally on out_ready only.
- Reset asserted mid-operation: all valids clear immediately, without waiting for a clock edge. Operation resumes on the first edge after release.

Test Plan:
- Directed select sweep, MID_REG=1, defaults: slot i = 32'hA5A50000+i, sel 0..31 streamed with out_ready=1. Required: out_data = 32'hA5A50000+sel, out_sel = sel, each result 2 cycles after acceptance, 32 results in 33 cycles.
- Group boundary: sel=15, 16, 31 with slot 15=32'h0000000F, 16=32'hDEAD0010, 31=32'hFFFFFFFF. Required: outputs equal those values exactly.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 with sels 3, 7, 9. Required: sels 3 and 7 accepted, then in_ready=0 and output held at slot 3. After out_ready=1: outputs in order 3, 7, 9, none lost or duplicated.
- Input change after accept: accept sel=4, then change slot 4 to 32'h12345678 the next cycle. Required: output is the original slot 4 value.
- Async reset mid-flight: accept 2 requests, pull reset low between clock edges. Required: out_valid=0 and out_data=0 immediately, and no stale result after release.
- MID_REG=0, WIDTH=8, SEL_BITS=3, GROUP_BITS=2: slot i = 8'h10+i, sel=6. Required: out_data=8'h16 one cycle after acceptance. A random 1000-request stream with random out_ready must match a reference-model queue.
